// File: rtl/inst_fetch.sv
// Two-wide instruction fetch: one outstanding imem request, decodes a 64-bit fetch pair into two issue slots.
// Define FETCH_BPRED_EN to predict backward branches and all JALs as taken (static prediction).
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [63:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        instbuf_full,
  output logic        stop,
  output logic [1:0]  issue,
  output logic [31:0] in1_inst,
  output logic [31:0] in1_pc,
  output logic [31:0] in1_npc,
  output logic [31:0] in2_inst,
  output logic [31:0] in2_pc,
  output logic [31:0] in2_npc,
  output logic        isbranch1,
  output logic        br_taken1,
  output logic        isbranch2,
  output logic        br_taken2
);
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_DROP} state_t;
  state_t state, state_nxt;

  logic [31:0] pc;
  logic [31:0] w1, w2, pc4, npc1, npc2;
  logic        br1, br2, tk1, tk2, xfer;

  function automatic logic is_br(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

`ifdef FETCH_BPRED_EN
  function automatic logic [31:0] imm_of(input logic [31:0] i);
    if (i[6:0] == OP_JAL)
      return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  // Static BTFN: backward conditional branches and every JAL predicted taken.
  function automatic logic taken(input logic [31:0] i);
    return ((i[6:0] == OP_BRANCH) && i[31]) || (i[6:0] == OP_JAL);
  endfunction
`endif

  always_comb begin
    w1  = imem_rdata[31:0];
    w2  = imem_rdata[63:32];
    pc4 = pc + 32'd4;
    br1 = is_br(w1[6:0]);
    br2 = is_br(w2[6:0]);
`ifdef FETCH_BPRED_EN
    tk1  = taken(w1);
    tk2  = taken(w2);
    npc1 = tk1 ? pc + imm_of(w1) : pc4;
    npc2 = tk2 ? pc4 + imm_of(w2) : pc + 32'd8;
`else
    tk1  = 1'b0;
    tk2  = 1'b0;
    npc1 = pc4;
    npc2 = pc + 32'd8;
`endif
  end

  assign xfer      = (state == S_OUT) && (issue != 2'b00) && !instbuf_full;
  assign stop      = redirect_valid;
  assign imem_addr = pc;
  // Suppressed under redirect so no response can arrive for a dropped PC.
  assign imem_req  = (state == S_REQ) && !rst && !redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (redirect_valid) begin
      case (state)
        S_WAIT:  state_nxt = imem_valid ? S_REQ : S_DROP;
        S_DROP:  state_nxt = imem_valid ? S_REQ : S_DROP;
        default: state_nxt = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ:  state_nxt = S_WAIT;
        S_WAIT: if (imem_valid) state_nxt = S_OUT;
        S_OUT:  if (xfer)       state_nxt = S_REQ;
        S_DROP: if (imem_valid) state_nxt = S_REQ;
        default: state_nxt = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      issue     <= 2'b00;
      in1_inst  <= '0; in1_pc <= '0; in1_npc <= '0;
      in2_inst  <= '0; in2_pc <= '0; in2_npc <= '0;
      isbranch1 <= 1'b0; br_taken1 <= 1'b0;
      isbranch2 <= 1'b0; br_taken2 <= 1'b0;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      issue <= 2'b00;
    end else if (state == S_WAIT && imem_valid) begin
      in1_inst  <= w1;
      in1_pc    <= pc;
      in1_npc   <= npc1;
      isbranch1 <= br1;
      br_taken1 <= tk1;
      if (tk1) begin
        // Slot 2 lies on the not-taken path; squash it.
        issue     <= 2'b01;
        in2_inst  <= '0; in2_pc <= '0; in2_npc <= '0;
        isbranch2 <= 1'b0; br_taken2 <= 1'b0;
      end else begin
        issue     <= 2'b11;
        in2_inst  <= w2;
        in2_pc    <= pc4;
        in2_npc   <= npc2;
        isbranch2 <= br2;
        br_taken2 <= tk2;
      end
    end else if (xfer) begin
      pc    <= (issue == 2'b01) ? in1_npc : in2_npc;
      issue <= 2'b00;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; expectations follow FETCH_BPRED_EN when it is defined.
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [63:0] imem_rdata = '0;
  logic        imem_valid = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instbuf_full = 1'b0;
  logic        stop;
  logic [1:0]  issue;
  logic [31:0] in1_inst, in1_pc, in1_npc, in2_inst, in2_pc, in2_npc;
  logic        isbranch1, br_taken1, isbranch2, br_taken2;

  int checks = 0;
  int passed = 0;

  localparam logic [31:0] ADDI1    = 32'h0010_0093;
  localparam logic [31:0] ADDI2    = 32'h0020_0113;
  localparam logic [31:0] BEQ_M16  = 32'hFE00_08E3;
  localparam logic [31:0] BEQ_P8   = 32'h0000_0463;
  localparam logic [31:0] JAL_P40  = 32'h0400_006F;
  localparam logic [31:0] JALR     = 32'h0000_8067;

  inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instbuf_full(instbuf_full), .stop(stop), .issue(issue),
    .in1_inst(in1_inst), .in1_pc(in1_pc), .in1_npc(in1_npc),
    .in2_inst(in2_inst), .in2_pc(in2_pc), .in2_npc(in2_npc),
    .isbranch1(isbranch1), .br_taken1(br_taken1),
    .isbranch2(isbranch2), .br_taken2(br_taken2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish before 200000");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Expects the DUT in REQ; answers the request one cycle later and leaves the DUT in OUT.
  task automatic do_fetch(input logic [63:0] data);
    checks++; if (imem_req !== 1'b1) $display("FAIL fetch_req: got %b required 1", imem_req); else passed++;
    tick;
    imem_valid = 1'b1;
    imem_rdata = data;
    tick;
    imem_valid = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] p);
    redirect_valid = 1'b1;
    redirect_pc    = p;
    #1;
    checks++; if (stop !== 1'b1) $display("FAIL redir_stop: got %b required 1", stop); else passed++;
    tick;
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== p) $display("FAIL redir_addr: got %h required %h", imem_addr, p); else passed++;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    checks++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b required 0", imem_req); else passed++;
    checks++; if (issue !== 2'b00) $display("FAIL rst_issue: got %b required 00", issue); else passed++;
    checks++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h required 0", imem_addr); else passed++;
    checks++; if ({in1_pc, in2_npc, in1_inst} !== 96'h0) $display("FAIL rst_slots: got %h required 0", {in1_pc, in2_npc, in1_inst}); else passed++;
    rst = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b1) $display("FAIL rst_first_req: got %b required 1", imem_req); else passed++;
  endtask

  task automatic test_basic;
    do_fetch({ADDI2, ADDI1});
    checks++; if (issue !== 2'b11) $display("FAIL basic_issue: got %b required 11", issue); else passed++;
    checks++; if ({in1_pc, in2_pc} !== {32'h0, 32'h4}) $display("FAIL basic_pc: got %h/%h required 0/4", in1_pc, in2_pc); else passed++;
    checks++; if ({in1_npc, in2_npc} !== {32'h4, 32'h8}) $display("FAIL basic_npc: got %h/%h required 4/8", in1_npc, in2_npc); else passed++;
    checks++; if ({in1_inst, in2_inst} !== {ADDI1, ADDI2}) $display("FAIL basic_inst: got %h/%h", in1_inst, in2_inst); else passed++;
    checks++; if ({isbranch1, br_taken1, isbranch2, br_taken2} !== 4'b0) $display("FAIL basic_br: got %b required 0000", {isbranch1, br_taken1, isbranch2, br_taken2}); else passed++;
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL basic_next: got req=%b addr=%h required 1/8", imem_req, imem_addr); else passed++;
    checks++; if (issue !== 2'b00) $display("FAIL basic_issue_drop: got %b required 00", issue); else passed++;
  endtask

  task automatic test_stall;
    do_fetch({ADDI1, ADDI2});
    instbuf_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      checks++; if (issue !== 2'b11 || in1_pc !== 32'h8 || in2_npc !== 32'h10 || imem_req !== 1'b0)
        $display("FAIL stall_hold%0d: got issue=%b pc=%h npc2=%h req=%b", i, issue, in1_pc, in2_npc, imem_req); else passed++;
    end
    instbuf_full = 1'b0;
    tick;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) $display("FAIL stall_release: got req=%b addr=%h required 1/10", imem_req, imem_addr); else passed++;
  endtask

  task automatic test_branch;
    redirect_to(32'h100);
    do_fetch({ADDI1, BEQ_M16});
    checks++; if (isbranch1 !== 1'b1) $display("FAIL beq_isbr: got %b required 1", isbranch1); else passed++;
`ifdef FETCH_BPRED_EN
    checks++; if (issue !== 2'b01 || br_taken1 !== 1'b1) $display("FAIL beq_taken: got issue=%b tk=%b required 01/1", issue, br_taken1); else passed++;
    checks++; if (in1_npc !== 32'hF0) $display("FAIL beq_npc: got %h required f0", in1_npc); else passed++;
    checks++; if ({in2_inst, in2_pc, in2_npc, isbranch2, br_taken2} !== 98'h0) $display("FAIL beq_squash: got %h/%h/%h", in2_inst, in2_pc, in2_npc); else passed++;
    tick;
    checks++; if (imem_addr !== 32'hF0) $display("FAIL beq_next: got %h required f0", imem_addr); else passed++;
`else
    checks++; if (issue !== 2'b11 || br_taken1 !== 1'b0) $display("FAIL beq_taken: got issue=%b tk=%b required 11/0", issue, br_taken1); else passed++;
    checks++; if (in1_npc !== 32'h104) $display("FAIL beq_npc: got %h required 104", in1_npc); else passed++;
    checks++; if (in2_pc !== 32'h104 || in2_npc !== 32'h108) $display("FAIL beq_slot2: got %h/%h required 104/108", in2_pc, in2_npc); else passed++;
    tick;
    checks++; if (imem_addr !== 32'h108) $display("FAIL beq_next: got %h required 108", imem_addr); else passed++;
`endif
  endtask

  task automatic test_jal;
    redirect_to(32'h200);
    do_fetch({JAL_P40, ADDI1});
    checks++; if (issue !== 2'b11 || in2_pc !== 32'h204 || isbranch2 !== 1'b1) $display("FAIL jal_slot2: got issue=%b pc=%h isbr=%b", issue, in2_pc, isbranch2); else passed++;
`ifdef FETCH_BPRED_EN
    checks++; if (in2_npc !== 32'h244 || br_taken2 !== 1'b1) $display("FAIL jal_npc: got %h tk=%b required 244/1", in2_npc, br_taken2); else passed++;
    tick;
    checks++; if (imem_addr !== 32'h244) $display("FAIL jal_next: got %h required 244", imem_addr); else passed++;
`else
    checks++; if (in2_npc !== 32'h208 || br_taken2 !== 1'b0) $display("FAIL jal_npc: got %h tk=%b required 208/0", in2_npc, br_taken2); else passed++;
    tick;
    checks++; if (imem_addr !== 32'h208) $display("FAIL jal_next: got %h required 208", imem_addr); else passed++;
`endif
  endtask

  task automatic test_wrap;
    redirect_to(32'hFFFF_FFF8);
    do_fetch({BEQ_P8, JALR});
    checks++; if (isbranch1 !== 1'b0 || in1_npc !== 32'hFFFF_FFFC) $display("FAIL jalr_slot1: got isbr=%b npc=%h required 0/fffffffc", isbranch1, in1_npc); else passed++;
    checks++; if (in2_pc !== 32'hFFFF_FFFC || isbranch2 !== 1'b1 || br_taken2 !== 1'b0) $display("FAIL fwd_slot2: got pc=%h isbr=%b tk=%b", in2_pc, isbranch2, br_taken2); else passed++;
    checks++; if (in2_npc !== 32'h0) $display("FAIL wrap_npc: got %h required 0", in2_npc); else passed++;
    tick;
    checks++; if (imem_addr !== 32'h0 || imem_req !== 1'b1) $display("FAIL wrap_next: got addr=%h req=%b required 0/1", imem_addr, imem_req); else passed++;
  endtask

  task automatic test_redirect_wait;
    tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h800;
    #1;
    checks++; if (stop !== 1'b1) $display("FAIL rw_stop: got %b required 1", stop); else passed++;
    tick;
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || issue !== 2'b00) $display("FAIL rw_drop: got req=%b issue=%b required 0/00", imem_req, issue); else passed++;
    tick;
    imem_valid = 1'b1;
    imem_rdata = {ADDI2, ADDI1};
    tick;
    imem_valid = 1'b0;
    #1;
    checks++; if (issue !== 2'b00) $display("FAIL rw_stale: got issue=%b required 00", issue); else passed++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h800) $display("FAIL rw_next: got req=%b addr=%h required 1/800", imem_req, imem_addr); else passed++;
    do_fetch({ADDI1, ADDI2});
    checks++; if (issue !== 2'b11 || in1_pc !== 32'h800 || in1_inst !== ADDI2) $display("FAIL rw_refetch: got issue=%b pc=%h inst=%h", issue, in1_pc, in1_inst); else passed++;
    tick;
  endtask

  task automatic test_redirect_out;
    do_fetch({ADDI2, ADDI1});
    instbuf_full = 1'b1;
    tick;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    tick;
    redirect_valid = 1'b0;
    instbuf_full   = 1'b0;
    #1;
    checks++; if (issue !== 2'b00 || imem_req !== 1'b1 || imem_addr !== 32'h400) $display("FAIL ro_redirect: got issue=%b req=%b addr=%h required 00/1/400", issue, imem_req, imem_addr); else passed++;
  endtask

  task automatic test_mid_reset;
    tick;
    rst            = 1'b1;
    imem_valid     = 1'b1;
    imem_rdata     = {JAL_P40, BEQ_M16};
    redirect_valid = 1'b1;
    redirect_pc    = 32'h900;
    tick;
    rst            = 1'b0;
    redirect_valid = 1'b0;
    #1;
    checks++; if (issue !== 2'b00 || in1_pc !== 32'h0 || in1_inst !== 32'h0) $display("FAIL mr_clear: got issue=%b pc=%h inst=%h", issue, in1_pc, in1_inst); else passed++;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL mr_req: got req=%b addr=%h required 1/0", imem_req, imem_addr); else passed++;
    tick;
    imem_valid = 1'b0;
    #1;
    checks++; if (issue !== 2'b00 || imem_req !== 1'b0) $display("FAIL mr_stale: got issue=%b req=%b required 00/0", issue, imem_req); else passed++;
    imem_valid = 1'b1;
    imem_rdata = {ADDI2, ADDI1};
    tick;
    imem_valid = 1'b0;
    checks++; if (issue !== 2'b11 || in1_inst !== ADDI1 || in2_pc !== 32'h4) $display("FAIL mr_consume: got issue=%b inst=%h pc2=%h", issue, in1_inst, in2_pc); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_branch;
    test_jal;
    test_wrap;
    test_redirect_wait;
    test_redirect_out;
    test_mid_reset;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
